// File: rtl/line_buffer_ctrl_pkg.sv
// Shared types and width helpers for the Sobel line-buffer controller.
package line_buf_pkg;

   typedef enum logic [1:0] {
      FILL0  = 2'd0,
      FILL1  = 2'd1,
      STEADY = 2'd2
   } lb_state_e;

   function automatic int addr_w(input int line_w);
      return $clog2(2 * line_w);
   endfunction

   function automatic int coord_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Column view at the default 8-bit pixel width; bot sits in the LSBs.
   localparam int COL_PIX_W = 8;
   typedef struct packed {
      logic [COL_PIX_W-1:0] top;
      logic [COL_PIX_W-1:0] mid;
      logic [COL_PIX_W-1:0] bot;
   } col_t;

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Bus between the line-buffer controller (master) and its dual-read/single-write RAM (slave).
interface line_buffer_ctrl_if
   import line_buf_pkg::*;
#(
   parameter int PIX_W  = 8,
   parameter int LINE_W = 640
);
   localparam int AW = addr_w(LINE_W);

   logic             ram_wr_en_o;
   logic             ram_rd_en_a_o;
   logic             ram_rd_en_b_o;
   logic [AW-1:0]    ram_wr_addr_o;
   logic [AW-1:0]    ram_rd_addr_a_o;
   logic [AW-1:0]    ram_rd_addr_b_o;
   logic [PIX_W-1:0] ram_data_o;
   logic [PIX_W-1:0] ram_data_a_i;
   logic [PIX_W-1:0] ram_data_b_i;

   modport master (
      output ram_wr_en_o, ram_rd_en_a_o, ram_rd_en_b_o,
      output ram_wr_addr_o, ram_rd_addr_a_o, ram_rd_addr_b_o, ram_data_o,
      input  ram_data_a_i, ram_data_b_i
   );

   modport slave (
      input  ram_wr_en_o, ram_rd_en_a_o, ram_rd_en_b_o,
      input  ram_wr_addr_o, ram_rd_addr_a_o, ram_rd_addr_b_o, ram_data_o,
      output ram_data_a_i, ram_data_b_i
   );
endinterface

// File: rtl/line_buffer_ctrl_raster_counter.sv
// Raster x/y position counters, advanced once per accepted pixel.
module raster_counter
   import line_buf_pkg::*;
#(
   parameter int LINE_W  = 640,
   parameter int FRAME_H = 480,
   localparam int XW = coord_w(LINE_W),
   localparam int YW = coord_w(FRAME_H)
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          adv_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          eol_o,
   output logic          eof_o
);
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   assign eol_o = (x_q == XW'(LINE_W - 1));
   assign eof_o = eol_o && (y_q == YW'(FRAME_H - 1));
   assign x_o   = x_q;
   assign y_o   = y_q;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (adv_i) begin
         if (eol_o) begin
            x_d = '0;
            y_d = eof_o ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end
endmodule

// File: rtl/line_buffer_ctrl.sv
// Raster stream to 3-tall pixel column using two RAM line banks with read-before-write.
// Define LINE_BUF_BORDER_ZERO_EN to zero the rows above the frame top instead of passing stale RAM.
//
// state  | meaning
// FILL0  | accepting row 0: no valid rows above
// FILL1  | accepting row 1: only y-1 is valid
// STEADY | rows 2..FRAME_H-1: full column valid
module line_buffer_ctrl
   import line_buf_pkg::*;
#(
   parameter int PIX_W   = 8,
   parameter int LINE_W  = 640,
   parameter int FRAME_H = 480,
   localparam int AW = addr_w(LINE_W),
   localparam int XW = coord_w(LINE_W),
   localparam int YW = coord_w(FRAME_H)
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic [PIX_W-1:0]   pix_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic [3*PIX_W-1:0] col_o,
   output logic [XW-1:0]      x_o,
   output logic [YW-1:0]      y_o,
   output logic               valid_o,
   input  logic               ready_i,
   line_buffer_ctrl_if.master ram
);
`ifdef LINE_BUF_BORDER_ZERO_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   typedef struct packed {
      logic [PIX_W-1:0] top;
      logic [PIX_W-1:0] mid;
      logic [PIX_W-1:0] bot;
   } pix_col_t;

   lb_state_e        state_q, state_d;
   logic             accept, eol, eof;
   logic [XW-1:0]    x_cur;
   logic [YW-1:0]    y_cur;
   logic [AW-1:0]    base_cur, base_prev;
   logic             valid_q, valid_d;
   logic [PIX_W-1:0] bot_q;
   logic [XW-1:0]    x_q;
   logic [YW-1:0]    y_q;
   logic             zero_top_d, zero_mid_d, zero_top_q, zero_mid_q;
   pix_col_t         col;

   assign ready_o = !valid_q || ready_i;
   // Gating with reset keeps the RAM strobes quiet while the counters are held.
   assign accept  = valid_i && ready_o && rstn_i;

   raster_counter #(
      .LINE_W  (LINE_W),
      .FRAME_H (FRAME_H)
   ) u_raster_counter (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .adv_i  (accept),
      .x_o    (x_cur),
      .y_o    (y_cur),
      .eol_o  (eol),
      .eof_o  (eof)
   );

   // Row y and row y-2 share a bank: port B fetches y-2 just as the write replaces it.
   assign base_cur  = y_cur[0] ? AW'(LINE_W) : '0;
   assign base_prev = y_cur[0] ? '0 : AW'(LINE_W);

   assign ram.ram_wr_en_o     = accept;
   assign ram.ram_rd_en_a_o   = accept;
   assign ram.ram_rd_en_b_o   = accept;
   assign ram.ram_wr_addr_o   = base_cur + AW'(x_cur);
   assign ram.ram_rd_addr_a_o = base_prev + AW'(x_cur);
   assign ram.ram_rd_addr_b_o = base_cur + AW'(x_cur);
   assign ram.ram_data_o      = pix_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= FILL0;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept && eol) begin
         case (state_q)
            FILL0:   state_d = FILL1;
            FILL1:   state_d = STEADY;
            STEADY:  if (eof) state_d = FILL0;
            default: state_d = FILL0;
         endcase
      end
   end

   always_comb begin
      zero_top_d = (state_q != STEADY);
      zero_mid_d = (state_q == FILL0);
   end

   always_comb begin
      valid_d = valid_q;
      if (accept)       valid_d = 1'b1;
      else if (ready_i) valid_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         valid_q    <= 1'b0;
         bot_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         zero_top_q <= 1'b0;
         zero_mid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (accept) begin
            bot_q      <= pix_i;
            x_q        <= x_cur;
            y_q        <= y_cur;
            zero_top_q <= zero_top_d;
            zero_mid_q <= zero_mid_d;
         end
      end
   end

   // RAM outputs are not reset, so mid/top are masked until a column is valid.
   always_comb begin
      col.bot = bot_q;
      col.mid = (valid_q && !(ZERO_EN && zero_mid_q)) ? ram.ram_data_a_i : '0;
      col.top = (valid_q && !(ZERO_EN && zero_top_q)) ? ram.ram_data_b_i : '0;
   end

   assign col_o   = col;
   assign x_o     = x_q;
   assign y_o     = y_q;
   assign valid_o = valid_q;
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl with LINE_W=4, FRAME_H=4 and a read-before-write RAM model.
`timescale 1ns/1ps
module tb_line_buffer_ctrl;
   import line_buf_pkg::*;

   localparam int PIX_W   = 8;
   localparam int LINE_W  = 4;
   localparam int FRAME_H = 4;
`ifdef LINE_BUF_BORDER_ZERO_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   typedef struct {
      col_t col;
      int   x;
      int   y;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       rstn_i;
   logic [7:0] pix_i;
   logic       valid_i, ready_o, valid_o, ready_i;
   logic [23:0] col_o;
   logic [1:0] x_o, y_o;

   line_buffer_ctrl_if #(.PIX_W(PIX_W), .LINE_W(LINE_W)) ram_bus ();

   line_buffer_ctrl #(.PIX_W(PIX_W), .LINE_W(LINE_W), .FRAME_H(FRAME_H)) dut (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .pix_i   (pix_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .col_o   (col_o),
      .x_o     (x_o),
      .y_o     (y_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .ram     (ram_bus)
   );

   always #5 clk_i = ~clk_i;

   logic [7:0] mem [0:7];
   always @(posedge clk_i) begin
      if (ram_bus.ram_rd_en_a_o) ram_bus.ram_data_a_i <= mem[ram_bus.ram_rd_addr_a_o];
      if (ram_bus.ram_rd_en_b_o) ram_bus.ram_data_b_i <= mem[ram_bus.ram_rd_addr_b_o];
      if (ram_bus.ram_wr_en_o)   mem[ram_bus.ram_wr_addr_o] <= ram_bus.ram_data_o;
   end

   int   n_cmp = 0, n_bad = 0;
   exp_t exp_q[$];
   logic [7:0] mbank [0:1][0:3];
   int   bx, by;
   bit   phase1 = 1'b0;
   int   ready_low_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit hand_col(input logic [7:0] p, output logic [23:0] c);
      c = '0;
      case (p)
         8'd9:  c = {8'd1, 8'd5, 8'd9};
         8'd16: c = {8'd8, 8'd12, 8'd16};
         8'd25: c = {8'd17, 8'd21, 8'd25};
         8'd5:  c = ZERO_EN ? {8'd0, 8'd1, 8'd5} : {8'hA4, 8'd1, 8'd5};
         8'd2:  c = ZERO_EN ? {8'd0, 8'd0, 8'd2} : {8'hA1, 8'hA5, 8'd2};
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   task automatic send(input logic [7:0] p);
      exp_t e;
      int   waits;
      logic [7:0] top, mid;
      valid_i = 1'b1;
      pix_i   = p;
      waits   = 0;
      @(negedge clk_i);
      while (!ready_o && waits < 20) begin
         @(negedge clk_i);
         waits++;
      end
      if (waits >= 20) check("ready_timeout", 32'(ready_o), 32'd1);
      top = mbank[by % 2][bx];
      mid = mbank[(by + 1) % 2][bx];
      if (ZERO_EN && by < 2) top = 8'd0;
      if (ZERO_EN && by == 0) mid = 8'd0;
      e.col.top = top;
      e.col.mid = mid;
      e.col.bot = p;
      e.x = bx;
      e.y = by;
      check("strobes", {29'd0, ram_bus.ram_wr_en_o, ram_bus.ram_rd_en_a_o, ram_bus.ram_rd_en_b_o}, 32'd7);
      check("wr_addr", 32'(ram_bus.ram_wr_addr_o), 32'((by % 2) * 4 + bx));
      check("rd_a_addr", 32'(ram_bus.ram_rd_addr_a_o), 32'(((by + 1) % 2) * 4 + bx));
      check("rd_b_addr", 32'(ram_bus.ram_rd_addr_b_o), 32'((by % 2) * 4 + bx));
      check("wr_data", 32'(ram_bus.ram_data_o), 32'(p));
      exp_q.push_back(e);
      mbank[by % 2][bx] = p;
      if (bx == LINE_W - 1) begin
         bx = 0;
         by = (by == FRAME_H - 1) ? 0 : by + 1;
      end else begin
         bx++;
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      logic [23:0] hc;
      forever begin
         @(negedge clk_i);
         if (phase1 && !ready_o) ready_low_cnt++;
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_col", 32'(col_o), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("col", 32'(col_o), 32'(e.col));
               check("x", 32'(x_o), 32'(e.x));
               check("y", 32'(y_o), 32'(e.y));
               if (hand_col(e.col.bot, hc)) check("hand_col", 32'(col_o), 32'(hc));
            end
         end
      end
   end

   initial begin : stim
      logic [23:0] held;
      rstn_i  = 1'b0;
      valid_i = 1'b1;
      pix_i   = 8'h55;
      ready_i = 1'b1;
      bx = 0;
      by = 0;
      for (int p = 0; p < 2; p++)
         for (int x = 0; x < 4; x++) begin
            mbank[p][x]  = 8'(8'hA0 + p * 4 + x);
            mem[p*4 + x] = 8'(8'hA0 + p * 4 + x);
         end

      @(negedge clk_i);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_x", 32'(x_o), 32'd0);
      check("rst_y", 32'(y_o), 32'd0);
      check("rst_col", 32'(col_o), 32'd0);
      check("rst_strobes", {29'd0, ram_bus.ram_wr_en_o, ram_bus.ram_rd_en_a_o, ram_bus.ram_rd_en_b_o}, 32'd0);
      @(posedge clk_i);
      #1;
      rstn_i  = 1'b1;
      valid_i = 1'b0;
      @(posedge clk_i);
      #1;

      phase1 = 1'b1;
      for (int p = 1; p <= 16; p++) begin
         send(8'(p));
         if (p == 13) begin
            check("same_addr_old", 32'(ram_bus.ram_data_b_i), 32'd5);
            check("same_addr_new", 32'(mem[4]), 32'd13);
         end
      end
      phase1 = 1'b0;
      check("ready_never_low", 32'(ready_low_cnt), 32'd0);

      for (int p = 17; p <= 32; p++) begin
         send(8'(p));
         if (p == 22) begin
            ready_i = 1'b0;
            valid_i = 1'b1;
            pix_i   = 8'd23;
            held    = '0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk_i);
               if (i == 0) held = col_o;
               else check("stall_col", 32'(col_o), 32'(held));
               check("stall_valid", 32'(valid_o), 32'd1);
               check("stall_ready", 32'(ready_o), 32'd0);
               check("stall_strobes", {29'd0, ram_bus.ram_wr_en_o, ram_bus.ram_rd_en_a_o, ram_bus.ram_rd_en_b_o}, 32'd0);
               @(posedge clk_i);
               #1;
            end
            ready_i = 1'b1;
         end
      end

      for (int p = 8'h61; p <= 8'h66; p++) send(8'(p));
      valid_i = 1'b1;
      pix_i   = 8'h67;
      @(negedge clk_i);
      #1;
      rstn_i = 1'b0;
      #1;
      check("arst_valid", 32'(valid_o), 32'd0);
      check("arst_x", 32'(x_o), 32'd0);
      check("arst_y", 32'(y_o), 32'd0);
      check("arst_col", 32'(col_o), 32'd0);
      check("arst_strobes", {29'd0, ram_bus.ram_wr_en_o, ram_bus.ram_rd_en_a_o, ram_bus.ram_rd_en_b_o}, 32'd0);
      @(posedge clk_i);
      #1;
      rstn_i = 1'b1;
      bx = 0;
      by = 0;
      send(8'h68);
      send(8'h69);

      valid_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      check("drain_valid", 32'(valid_o), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

- Streaming controller that turns a raster pixel stream into a 3-tall pixel column (rows y-2, y-1, y) for the Sobel 3x3 window.
- Acts as the initiator on an external dual-read/single-write synchronous RAM, which is instantiated alongside it with `WIDTH_P=PIX_W` and `DEPTH_P=2*LINE_W`.
- Uses two line banks in the RAM with read-before-write reuse of the y-2 slot.
- Sits between the pixel ingest stage and the window/convolution stage.

## Interface
Parameters:
- PIX_W, 8, pixel width in bits
- LINE_W, 640, pixels per line (≥2)
- FRAME_H, 480, lines per frame (≥3)

Ports:
- clk_i  in  1  clock, all logic on posedge
- rstn_i  in  1  reset, asynchronous, active-low
- pix_i  in  PIX_W  input pixel
- valid_i  in  1  input pixel valid
- ready_o  out  1  input accept; beat transfers when valid_i && ready_o
- col_o  out  3*PIX_W  {top=y-2, mid=y-1, bot=y}; bot in LSBs
- x_o  out  $clog2(LINE_W)  column of bot pixel
- y_o  out  $clog2(FRAME_H)  row of bot pixel
- valid_o  out  1  output column valid
- ready_i  in  1  downstream accept
- ram_wr_en_o, ram_rd_en_a_o, ram_rd_en_b_o  out  1 each  RAM strobes
- ram_wr_addr_o, ram_rd_addr_a_o, ram_rd_addr_b_o  out  $clog2(2*LINE_W) each  RAM addresses
- ram_data_o  out  PIX_W  RAM write data (= pix_i)
- ram_data_a_i, ram_data_b_i  in  PIX_W each  RAM read data, 1-cycle latency

## Operation
- Bank base is `(y[0] ? LINE_W : 0)`.
- On an accepted beat at (x,y), all three RAM strobes pulse for one cycle:
  - port A reads `bankbase(y-1)+x` (mid);
  - port B reads `bankbase(y)+x` (old y-2 data, i.e. top);
  - the write goes to `bankbase(y)+x`.
- The RAM returns the pre-write value on a same-cycle read and write of one address; read-before-write is relied on.
- Strobes are low on every non-accept cycle. The RAM then holds its outputs, so col_o stays stable under stall.
- Counters advance per accepted beat:
  - x wraps LINE_W-1→0 and increments y;
  - y wraps FRAME_H-1→0, with bank parity restarting at 0.
- FSM on the accepted row:
  - FILL0 (y=0) → FILL1 at the end of line 0;
  - FILL1 (y=1) → STEADY at the end of line 1;
  - STEADY → FILL0 at the end of line FRAME_H-1.
- FSM state sampled with the beat selects border handling (see Configuration).
- ready_o = !valid_o || ready_i (single-stage pipeline, no bubble under continuous flow).

## Timing
- Latency is 1 cycle: a beat accepted at edge t gives valid_o=1 after t, with col_o bot = registered pixel and mid/top = ram_data_a_i/ram_data_b_i.
- valid_o drops after an edge where valid_o && ready_i && !(valid_i && ready_o).
- Simultaneous output handshake and input accept: valid_o stays 1 and the new column replaces the old.
- Reset (async, any cycle) clears:
  - valid_o=0, x/y=0, FSM=FILL0, all RAM strobes=0, col_o=0, x_o=0, y_o=0.
  - RAM contents are not cleared.
- Reset mid-frame restarts at (0,0). Stale RAM data is never exposed as valid when LINE_BUF_BORDER_ZERO_EN is set.
- ready_o is combinational from valid_o and ready_i.

## Configuration
- LINE_BUF_BORDER_ZERO_EN defined:
  - top forced to 0 when the beat was accepted in FILL0 or FILL1;
  - mid forced to 0 in FILL0.
- LINE_BUF_BORDER_ZERO_EN undefined: raw RAM data is passed. Columns for y<2 carry stale or uninitialised contents; consumers gate on y_o.

## Structure
- Package line_buf_pkg holds:
  - the FSM enum (FILL0, FILL1, STEADY);
  - the address-width and coordinate-width localparam functions;
  - a col_t packed struct {top, mid, bot}.
- One sub-module, raster_counter: x/y counters with the advance enable, wrap outputs eol/eof, and parameters LINE_W and FRAME_H.
- RAM instantiation is done by the enclosing sobel top, not inside this block.

## Test plan
All scenarios use LINE_W=4, FRAME_H=4, bench RAM model with read-before-write.

- Continuous stream of pixels 1..16 with ready_i=1:
  - pixel 9 (x=0,y=2) → col_o {1,5,9} one cycle after accept;
  - pixel 16 → {8,12,16};
  - ready_o is never low.
- Same stream with ZERO_EN:
  - pixel 5 → {0,1,5};
  - pixel 2 → {0,0,2}.
- ready_i held low 3 cycles while valid_o=1:
  - col_o constant;
  - ready_o=0;
  - no RAM strobes;
  - resumes with no loss or duplication.
- Second frame 17..32 streamed immediately after the first: pixel 25 (y=2) → {17,21,25}, proving bank parity restarts at the y wrap.
- Same-address check at pixel 13 (x=0,y=3) writing bank 1 addr 4: port B returns the old row-1 value 5 and the RAM then holds 13.
- Assert rstn_i during pixel 7:
  - async clear of valid_o, x_o and y_o;
  - the next accepted pixel is treated as (0,0).
